// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI result transmit path.
// Parity bit appended when SPI_TX_PARITY_EN is defined.
package spi_pkg;

  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] IDLE_WORD_DEF = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int frame_len(input int dw);
`ifdef SPI_TX_PARITY_EN
    return dw + 1;
`else
    return dw;
`endif
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with rising/falling edge detect
// for an asynchronous SPI pin.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_cur;

  assign w_cur = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_cur;
    end
  end

  assign o_rise = w_cur & ~r_prev;
  assign o_fall = ~w_cur & r_prev;

endmodule

// File: rtl/spi_result_tx.sv
// SPI mode-0 slave transmit path for result words, oversampled in CLK.
// Define SPI_TX_PARITY_EN to append an odd-parity bit per frame.
module spi_result_tx
  import spi_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD   = IDLE_WORD_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  input  logic              SCLK,
  input  logic              CS_N,
  output logic              MISO,
  output logic              MISO_OE,
  output logic              TX_DONE,
  output logic              UNDERRUN,
  output logic              ABORT
);

  localparam int FL = frame_len(DATA_W);
  localparam int CW = $clog2(DATA_W + 2);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_sclk_sync (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_async(SCLK),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b1)
  ) u_cs_sync (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_async(CS_N),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  state_t            r_state;
  logic [DATA_W-1:0] r_hold;
  logic              r_full;
  logic [FL-1:0]     r_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_done;
  logic              r_abort;
  logic              r_under;

  logic              w_start;
  logic              w_xfer;
  logic              w_accept;
  logic [DATA_W-1:0] w_word;
  logic [FL-1:0]     w_frame;
  logic [CW-1:0]     w_cnt_nx;

  assign w_start  = (r_state == S_IDLE) && w_cs_fall;
  assign w_xfer   = w_start && r_full;
  // A word offered on the transfer cycle refills the register.
  assign w_accept = TX_VALID && (!r_full || w_xfer);
  assign w_word   = r_full ? r_hold : IDLE_WORD;
  assign w_cnt_nx = r_cnt + 1'b1;

`ifdef SPI_TX_PARITY_EN
  assign w_frame = {w_word, ~^w_word};
`else
  assign w_frame = w_word;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_hold <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= TX_DATA;
        r_full <= 1'b1;
      end else if (w_xfer) begin
        r_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_shift <= w_frame;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
            if (!r_full) r_under <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_cs_rise) begin
            r_abort <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_sck_rise) begin
            r_cnt <= w_cnt_nx;
            if (w_cnt_nx == CW'(FL)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (w_sck_fall) begin
            r_shift <= {r_shift[FL-2:0], 1'b0};
          end
        end
        S_DONE: begin
          if (w_cs_rise) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign TX_READY = ~r_full;
  assign MISO_OE  = (r_state != S_IDLE);
  assign MISO     = MISO_OE & r_shift[FL-1];
  assign TX_DONE  = r_done;
  assign ABORT    = r_abort;
  assign UNDERRUN = r_under;

endmodule
